fifo_bit_unpacker: RTL and testbench
====================================

// Module: fifo_bit_unpacker
// PURPOSE
// - Consumer (read side) for the 1-bit FIFO1 instance: pops bits through the FIFO's
//   EMPTY_N/D_OUT/DEQ interface and packs them into WIDTH-bit words.
// - Presents each packed word downstream on a valid/ready handshake.
// - Drives the FIFO CLR line on a flush, so the FIFO and the unpacker always discard together.
// PARAMETERS
// - WIDTH      8  bits per output word (2..32)
// - MSB_FIRST  1  1: first popped bit -> WORD_OUT[WIDTH-1]; 0: first popped bit -> WORD_OUT[0]
// PORTS
// - CLK           in   1                    clock; all state updates on rising edge
// - RST           in   1                    synchronous reset, active-low
// - FIFO_EMPTY_N  in   1                    1 = FIFO holds a bit; FIFO_D_OUT valid
// - FIFO_D_OUT    in   1                    FIFO head bit
// - FIFO_DEQ      out  1                    pop FIFO head at this edge
// - FIFO_CLR      out  1                    clear FIFO contents
// - FLUSH         in   1                    discard partial/held word and clear FIFO
// - WORD_OUT      out  WIDTH                packed word
// - WORD_VALID    out  1                    WORD_OUT holds a complete word
// - WORD_READY    in   1                    downstream accepts WORD_OUT
// - BIT_CNT       out  $clog2(WIDTH+1)      bits collected into the current partial word
// - WORD_CNT      out  16                   words accepted since reset; wraps 0xFFFF->0
// BEHAVIOUR
// - Reset (RST=0 at an edge): state=COLLECT; WORD_OUT, WORD_VALID, BIT_CNT, WORD_CNT and the shift register all 0.
// - While RST=0, FIFO_DEQ=0 and FIFO_CLR=0 combinationally.
// - FIFO_DEQ = RST & FIFO_EMPTY_N & (state==COLLECT) & ~FLUSH (combinational).
// - FIFO_DEQ is never high while FIFO_EMPTY_N=0.
// - FIFO_CLR = RST & FLUSH (combinational, same-cycle pulse).
// - State COLLECT:
//   - Each DEQ cycle shifts FIFO_D_OUT into the shift register and increments BIT_CNT.
//   - On the DEQ with BIT_CNT==WIDTH-1: load WORD_OUT from shift register + current bit;
//     WORD_VALID<=1, BIT_CNT<=0, state<=HOLD.
//   - Latency: WORD_VALID is high the cycle after the WIDTH-th DEQ.
// - State HOLD:
//   - WORD_OUT and WORD_VALID are held stable and FIFO_DEQ=0 (backpressure lands in the FIFO).
//   - On WORD_READY=1: WORD_VALID<=0, WORD_CNT<=WORD_CNT+1 (mod 2^16), state<=COLLECT.
//   - The next DEQ can occur on the following cycle.
//   - Peak throughput: one word per WIDTH+1 cycles.
// - WORD_READY outside HOLD is ignored.
// - FLUSH at an edge in any state:
//   - Shift register and BIT_CNT cleared to 0; WORD_VALID<=0; state<=COLLECT.
//   - WORD_OUT keeps its last value (don't-care while invalid); WORD_CNT unchanged.
// - FLUSH together with WORD_READY in HOLD: FLUSH wins; the word is dropped and not counted.
// - FLUSH together with FIFO_EMPTY_N=1: no DEQ. The FIFO head is cleared by FIFO_CLR, not consumed.
// - RST=0 mid-word or in HOLD: everything returns to reset values at that edge; the partial word is lost.
// - WIDTH-bit arithmetic only; the counters never exceed their ranges.
// STRUCTURE
// - Shared package fifo_if_pkg:
//   - state encoding localparams ST_COLLECT=1'b0, ST_HOLD=1'b1;
//   - WORD_CNT_W=16;
//   - macro for counter width $clog2(WIDTH+1).
// - Sub-module bit_packer (WIDTH, MSB_FIRST):
//   - contains the shift register and BIT_CNT;
//   - inputs: shift_en, bit_in, clr;
//   - outputs: word (including the current bit), last (BIT_CNT==WIDTH-1).
// - The top level holds the FSM, handshake logic and WORD_CNT.
// TESTING (WIDTH=8, MSB_FIRST=1 unless noted)
// - Reset: RST=0 for 3 cycles with FIFO_EMPTY_N=1, FLUSH=1
//   -> FIFO_DEQ=0, FIFO_CLR=0, WORD_VALID=0, WORD_OUT=0, BIT_CNT=0, WORD_CNT=0.
// - Stream: EMPTY_N=1 feeding bits 1,0,1,0,0,1,0,1 back-to-back, READY=1
//   -> 8 DEQ pulses; WORD_OUT=8'hA5 with VALID one cycle after the 8th DEQ; WORD_CNT=1.
//   - With MSB_FIRST=0 the same bits -> WORD_OUT=8'hA5 bit-reversed = 8'hA5 (palindrome);
//     therefore also run 1,1,0,0,0,0,0,0 -> 8'h03.
// - Backpressure: READY=0 for 5 cycles in HOLD
//   -> FIFO_DEQ=0 throughout, WORD_OUT stable at 8'hA5;
//   -> READY=1: VALID drops the next cycle and DEQ resumes the cycle after.
// - Sparse FIFO: EMPTY_N alternates 1/0
//   -> DEQ only in EMPTY_N=1 cycles; BIT_CNT steps every other cycle; final word 8'hA5.
// - Flush: FLUSH after 3 bits
//   -> FIFO_CLR high that cycle, BIT_CNT=0, no DEQ; next 8 bits give a fresh correct word.
//   - FLUSH+READY in HOLD -> VALID=0, WORD_CNT unchanged.
// - Reset mid-word after 5 bits
//   -> all outputs 0; the next 8 bits produce the correct word.
//   - Preload WORD_CNT to 0xFFFF via 65535 words (or force) then accept one -> 0x0000.

Source files
------------

// File: rtl/fifo_bit_unpacker_pkg.sv
// Shared types and constants for the 1-bit FIFO unpacker.
// FSM encoding, counter widths and a width helper.
`ifndef FIFO_IF_CNT_W
`define FIFO_IF_CNT_W(w) $clog2((w)+1)
`endif

package fifo_if_pkg;

  localparam logic ST_COLLECT = 1'b0;
  localparam logic ST_HOLD    = 1'b1;
  localparam int   WORD_CNT_W = 16;

  typedef enum logic {
    COLLECT = ST_COLLECT,
    HOLD    = ST_HOLD
  } state_e;

  function automatic int cnt_w(input int w);
    return `FIFO_IF_CNT_W(w);
  endfunction

endpackage

// File: rtl/fifo_bit_unpacker_if.sv
// FIFO read port plus packed-word valid/ready bus.
// master = unpacker side, slave = FIFO/downstream side.
interface fifo_bit_unpacker_if #(
  parameter int WIDTH = 8
);

  logic             FIFO_EMPTY_N;
  logic             FIFO_D_OUT;
  logic             FIFO_DEQ;
  logic             FIFO_CLR;
  logic [WIDTH-1:0] WORD_OUT;
  logic             WORD_VALID;
  logic             WORD_READY;

  modport master (
    input  FIFO_EMPTY_N,
    input  FIFO_D_OUT,
    input  WORD_READY,
    output FIFO_DEQ,
    output FIFO_CLR,
    output WORD_OUT,
    output WORD_VALID
  );

  modport slave (
    output FIFO_EMPTY_N,
    output FIFO_D_OUT,
    output WORD_READY,
    input  FIFO_DEQ,
    input  FIFO_CLR,
    input  WORD_OUT,
    input  WORD_VALID
  );

endinterface

// File: rtl/fifo_bit_unpacker_bit_packer.sv
// Shift register and bit counter for one partial word.
// word already includes bit_in so the top can latch it on the last pop.
module bit_packer
  import fifo_if_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int CW        = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             clr,
  output logic [WIDTH-1:0] word,
  output logic             last,
  output logic [CW-1:0]    bit_cnt
);

  logic [WIDTH-2:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] sr_shift;

  generate
    if (MSB_FIRST) begin : g_msb
      assign word     = {sr_q, bit_in};
      assign sr_shift = word[WIDTH-2:0];
    end else begin : g_lsb
      assign word     = {bit_in, sr_q};
      assign sr_shift = word[WIDTH-1:1];
    end
  endgenerate

  assign last    = (cnt_q == CW'(WIDTH-1));
  assign bit_cnt = cnt_q;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift_en) begin
      if (last) begin
        sr_d  = '0;
        cnt_d = '0;
      end else begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_bit_unpacker.sv
// Pops bits from a 1-bit FIFO and emits WIDTH-bit words on valid/ready.
// FLUSH clears the FIFO and the partial/held word in the same cycle.
module fifo_bit_unpacker
  import fifo_if_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int CW        = cnt_w(WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH,
  fifo_bit_unpacker_if.master   bus,
  output logic [CW-1:0]         BIT_CNT,
  output logic [WORD_CNT_W-1:0] WORD_CNT
);

  state_e                  state_q;
  logic [WIDTH-1:0]        word_q;
  logic                    valid_q;
  logic [WORD_CNT_W-1:0]   word_cnt_q;
  logic [WORD_CNT_W-1:0]   word_cnt_d;
  logic [WIDTH-1:0]        pk_word;
  logic                    pk_last;
  logic                    deq;

  // FLUSH suppresses the pop: the head is discarded by FIFO_CLR instead.
  assign deq = RST & bus.FIFO_EMPTY_N
             & (state_q == COLLECT) & ~FLUSH;

  assign bus.FIFO_DEQ   = deq;
  assign bus.FIFO_CLR   = RST & FLUSH;
  assign bus.WORD_OUT   = word_q;
  assign bus.WORD_VALID = valid_q;
  assign WORD_CNT       = word_cnt_q;
  assign word_cnt_d     = word_cnt_q + 16'd1;

  bit_packer #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_packer (
    .clk      (CLK),
    .rst_n    (RST),
    .shift_en (deq),
    .bit_in   (bus.FIFO_D_OUT),
    .clr      (FLUSH),
    .word     (pk_word),
    .last     (pk_last),
    .bit_cnt  (BIT_CNT)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= COLLECT;
      word_q     <= '0;
      valid_q    <= 1'b0;
      word_cnt_q <= '0;
    end else if (FLUSH) begin
      state_q <= COLLECT;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (deq && pk_last) begin
            word_q  <= pk_word;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (bus.WORD_READY) begin
            valid_q    <= 1'b0;
            word_cnt_q <= word_cnt_d;
            state_q    <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_bit_unpacker.sv
// Directed bench: MSB-first and LSB-first units fed identical bit streams.
// Inputs driven after negedge, outputs sampled 1ns later.
module tb_fifo_bit_unpacker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b1;
  logic empty_n = 1'b1;
  logic d_out = 1'b0;
  logic ready = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0]  bcnt0, bcnt1;
  logic [15:0] wcnt0, wcnt1;

  always #5 clk = ~clk;

  fifo_bit_unpacker_if #(.WIDTH(8)) bus0 ();
  fifo_bit_unpacker_if #(.WIDTH(8)) bus1 ();

  assign bus0.FIFO_EMPTY_N = empty_n;
  assign bus0.FIFO_D_OUT   = d_out;
  assign bus0.WORD_READY   = ready;
  assign bus1.FIFO_EMPTY_N = empty_n;
  assign bus1.FIFO_D_OUT   = d_out;
  assign bus1.WORD_READY   = ready;

  fifo_bit_unpacker #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (
    .CLK(clk), .RST(rst), .FLUSH(flush), .bus(bus0),
    .BIT_CNT(bcnt0), .WORD_CNT(wcnt0)
  );

  fifo_bit_unpacker #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (
    .CLK(clk), .RST(rst), .FLUSH(flush), .bus(bus1),
    .BIT_CNT(bcnt1), .WORD_CNT(wcnt1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic b);
    empty_n = 1'b1;
    d_out   = b;
    #1;
    chk("push_deq", 32'(bus0.FIFO_DEQ), 32'd1);
    @(negedge clk);
  endtask

  // bits[7] is popped first
  task automatic send_word(input logic [7:0] bits,
                           input bit sparse,
                           input logic [7:0] exp_lsb);
    for (int i = 0; i < 8; i++) begin
      if (sparse) begin
        empty_n = 1'b0;
        #1;
        chk("sp_deq", 32'(bus0.FIFO_DEQ), 32'd0);
        chk("sp_bcnt", 32'(bcnt0), 32'(i));
        @(negedge clk);
      end
      empty_n = 1'b1;
      d_out   = bits[7-i];
      #1;
      chk("deq", 32'(bus0.FIFO_DEQ), 32'd1);
      chk("bcnt", 32'(bcnt0), 32'(i));
      chk("lat", 32'(bus0.WORD_VALID), 32'd0);
      @(negedge clk);
    end
    empty_n = 1'b0;
    #1;
    chk("valid", 32'(bus0.WORD_VALID), 32'd1);
    chk("word", 32'(bus0.WORD_OUT), 32'(bits));
    chk("lsb_word", 32'(bus1.WORD_OUT), 32'(exp_lsb));
    chk("bcnt0", 32'(bcnt0), 32'd0);
  endtask

  task automatic accept(input logic [15:0] cnt_exp);
    ready = 1'b1;
    #1;
    chk("acc_valid", 32'(bus0.WORD_VALID), 32'd1);
    @(negedge clk);
    ready = 1'b0;
    #1;
    chk("acc_drop", 32'(bus0.WORD_VALID), 32'd0);
    chk("wcnt", 32'(wcnt0), 32'(cnt_exp));
  endtask

  initial begin
    // reset with EMPTY_N and FLUSH asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_deq", 32'(bus0.FIFO_DEQ), 32'd0);
    chk("rst_clr", 32'(bus0.FIFO_CLR), 32'd0);
    chk("rst_valid", 32'(bus0.WORD_VALID), 32'd0);
    chk("rst_word", 32'(bus0.WORD_OUT), 32'd0);
    chk("rst_bcnt", 32'(bcnt0), 32'd0);
    chk("rst_wcnt", 32'(wcnt0), 32'd0);
    rst = 1'b1;
    flush = 1'b0;
    empty_n = 1'b0;
    @(negedge clk);

    // back-to-back stream
    send_word(8'hA5, 1'b0, 8'hA5);
    accept(16'd1);
    @(negedge clk);

    // backpressure
    send_word(8'hA5, 1'b0, 8'hA5);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      empty_n = 1'b1;
      ready   = 1'b0;
      #1;
      chk("bp_deq", 32'(bus0.FIFO_DEQ), 32'd0);
      chk("bp_word", 32'(bus0.WORD_OUT), 32'hA5);
      chk("bp_valid", 32'(bus0.WORD_VALID), 32'd1);
      @(negedge clk);
    end
    ready = 1'b1;
    #1;
    chk("bp_rdy_deq", 32'(bus0.FIFO_DEQ), 32'd0);
    @(negedge clk);
    ready = 1'b0;
    d_out = 1'b1;
    #1;
    chk("bp_vdrop", 32'(bus0.WORD_VALID), 32'd0);
    chk("bp_resume", 32'(bus0.FIFO_DEQ), 32'd1);
    chk("bp_wcnt", 32'(wcnt0), 32'd2);
    @(negedge clk);

    // flush after 3 bits
    push(1'b0);
    push(1'b1);
    flush = 1'b1;
    empty_n = 1'b1;
    #1;
    chk("fl_clr", 32'(bus0.FIFO_CLR), 32'd1);
    chk("fl_deq", 32'(bus0.FIFO_DEQ), 32'd0);
    chk("fl_bcnt3", 32'(bcnt0), 32'd3);
    @(negedge clk);
    flush = 1'b0;
    empty_n = 1'b0;
    #1;
    chk("fl_bcnt", 32'(bcnt0), 32'd0);
    chk("fl_clr0", 32'(bus0.FIFO_CLR), 32'd0);
    send_word(8'h3C, 1'b0, 8'h3C);
    accept(16'd3);
    @(negedge clk);

    // sparse FIFO
    send_word(8'hA5, 1'b1, 8'hA5);
    accept(16'd4);
    @(negedge clk);

    // bit order: LSB-first unit sees the reversal
    send_word(8'hC0, 1'b0, 8'h03);
    accept(16'd5);
    @(negedge clk);

    // flush wins over ready in HOLD
    send_word(8'h5A, 1'b0, 8'h5A);
    ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("fr_clr", 32'(bus0.FIFO_CLR), 32'd1);
    @(negedge clk);
    ready = 1'b0;
    flush = 1'b0;
    #1;
    chk("fr_valid", 32'(bus0.WORD_VALID), 32'd0);
    chk("fr_wcnt", 32'(wcnt0), 32'd5);
    @(negedge clk);

    // reset mid-word
    for (int i = 0; i < 5; i++) push(i[0]);
    rst = 1'b0;
    empty_n = 1'b1;
    #1;
    chk("mr_deq", 32'(bus0.FIFO_DEQ), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    empty_n = 1'b0;
    #1;
    chk("mr_word", 32'(bus0.WORD_OUT), 32'd0);
    chk("mr_valid", 32'(bus0.WORD_VALID), 32'd0);
    chk("mr_bcnt", 32'(bcnt0), 32'd0);
    chk("mr_wcnt", 32'(wcnt0), 32'd0);
    send_word(8'hC3, 1'b0, 8'hC3);
    accept(16'd1);
    @(negedge clk);

    // word counter wrap
    force dut0.word_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut0.word_cnt_q;
    #1;
    chk("wr_pre", 32'(wcnt0), 32'h0000FFFF);
    send_word(8'h81, 1'b0, 8'h81);
    accept(16'h0000);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
